// File: rtl/decoder_scan_ctrl.sv
// Round-robin scan sequencer for a 74HC138-style 3-to-8 decoder.
// Each enabled channel gets a blanking gap (outputs off, address settled), then a fixed dwell with outputs on.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_CYC = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] chan_mask,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       S1,
  output logic       S2N,
  output logic       S3N,
  output logic       En,
  output logic [2:0] cur_chan,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       addr_q, addr_d;
  logic             frame_q, frame_d;
  logic             s1_q, s2n_q, s3n_q, en_q;
  logic             on_d;

  logic [2:0] low_chan;
  logic       low_found;
  logic [2:0] up_chan;
  logic       up_found;

  // Lowest set mask bit, and the lowest set bit strictly above the current address.
  always_comb begin
    low_chan  = '0;
    low_found = 1'b0;
    up_chan   = '0;
    up_found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (chan_mask[i[2:0]] && !low_found) begin
        low_chan  = i[2:0];
        low_found = 1'b1;
      end
      if (chan_mask[i[2:0]] && !up_found && (i[2:0] > addr_q)) begin
        up_chan  = i[2:0];
        up_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    on_d    = s1_q;
    frame_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        on_d  = 1'b0;
        cnt_d = '0;
        if (run && low_found) begin
          addr_d  = low_chan;
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        on_d = 1'b0;
        if (!run) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = ST_DWELL;
          cnt_d   = '0;
          on_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DWELL: begin
        if (!run) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          on_d    = 1'b0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          on_d  = 1'b0;
          if (!low_found) begin
            state_d = ST_IDLE;
          end else begin
            // No set bit above the current channel means the scan wraps.
            state_d = ST_BLANK;
            addr_d  = up_found ? up_chan : low_chan;
            frame_d = !up_found;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        on_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      frame_q <= 1'b0;
      s1_q    <= 1'b0;
      s2n_q   <= 1'b1;
      s3n_q   <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      frame_q <= frame_d;
      s1_q    <= on_d;
      s2n_q   <= !on_d;
      s3n_q   <= !on_d;
      en_q    <= on_d;
    end
  end

  assign A0         = addr_q[0];
  assign A1         = addr_q[1];
  assign A2         = addr_q[2];
  assign cur_chan   = addr_q;
  assign S1         = s1_q;
  assign S2N        = s2n_q;
  assign S3N        = s3n_q;
  assign En         = en_q;
  assign busy       = (state_q == ST_BLANK) || (state_q == ST_DWELL);
  assign frame_done = frame_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: a slot-position reference model queues the
// expected outputs after every clock edge; a monitor pops and compares on the falling edge.
module tb_decoder_scan_ctrl;

  localparam int unsigned DW   = 4;
  localparam int unsigned BL   = 2;
  localparam int          SLOT = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] chan_mask;
  logic       A0, A1, A2, S1, S2N, S3N, En, busy, frame_done;
  logic [2:0] cur_chan;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(
    .DWELL_CYC(DW),
    .BLANK_CYC(BL),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .chan_mask(chan_mask),
    .A0(A0),
    .A1(A1),
    .A2(A2),
    .S1(S1),
    .S2N(S2N),
    .S3N(S3N),
    .En(En),
    .cur_chan(cur_chan),
    .busy(busy),
    .frame_done(frame_done)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  logic [11:0] exp_q[$];

  // Reference model: a scan is a sequence of slots of BL+DW cycles; pos is the offset in the slot.
  bit m_active = 1'b0;
  int m_chan   = 0;
  int m_pos    = 0;
  bit m_frame  = 1'b0;

  function automatic int lowest(input logic [7:0] m);
    for (int c = 0; c < 8; c++) if (m[3'(c)]) return c;
    return 0;
  endfunction

  function automatic int next_after(input logic [7:0] m, input int cur);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (cur + k) % 8;
      if (m[3'(c)]) return c;
    end
    return cur;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 1'b0; m_chan = 0; m_pos = 0; m_frame = 1'b0;
    end else if (!m_active) begin
      m_frame = 1'b0;
      if (run && chan_mask != 8'h00) begin
        m_active = 1'b1; m_chan = lowest(chan_mask); m_pos = 0;
      end
    end else if (!run) begin
      m_active = 1'b0; m_pos = 0; m_frame = 1'b0;
    end else if (m_pos == SLOT - 1) begin
      if (chan_mask == 8'h00) begin
        m_active = 1'b0; m_pos = 0; m_frame = 1'b0;
      end else begin
        int nxt;
        nxt     = next_after(chan_mask, m_chan);
        m_frame = (nxt <= m_chan);
        m_chan  = nxt;
        m_pos   = 0;
      end
    end else begin
      m_pos   = m_pos + 1;
      m_frame = 1'b0;
    end
  endtask

  function automatic logic [11:0] model_out();
    logic       on;
    logic [2:0] ch;
    on = m_active && (m_pos >= int'(BL));
    ch = 3'(m_chan);
    return {ch, ch, on, !on, !on, on, m_active, m_frame};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    exp_q.push_back(model_out());
    cyc++;
  endtask

  // Monitor: {cur_chan, A2,A1,A0, S1,S2N,S3N,En, busy, frame_done}
  initial begin
    logic [11:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {cur_chan, A2, A1, A0, S1, S2N, S3N, En, busy, frame_done};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %b required %b (chan,addr,S1,S2N,S3N,En,busy,frame)",
                   cyc, a, e);
        end
      end
    end
  end

  task automatic wait_model(input int ch, input int pos, input string name);
    int k;
    k = 0;
    while (!(m_active && m_chan == ch && m_pos == pos) && k < 300) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL %s timeout: channel %0d pos %0d not reached, got chan %0d pos %0d",
               name, ch, pos, m_chan, m_pos);
    end
  endtask

  task automatic async_reset_check(input string name);
    logic [5:0] a;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    a = {S1, S2N, S3N, En, frame_done, busy};
    n_tests++;
    if (a !== 6'b011000) begin
      n_fail++;
      $display("FAIL %s: got {S1,S2N,S3N,En,frame,busy}=%b required 011000", name, a);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    chan_mask = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Full mask scan, two frames.
    run = 1'b1; chan_mask = 8'hFF;
    repeat (16 * SLOT + 3) tick();

    // Sparse mask 2,5,7.
    chan_mask = 8'b1010_0100;
    repeat (7 * SLOT) tick();

    // Single channel.
    chan_mask = 8'h10;
    repeat (5 * SLOT) tick();

    // run dropped on the second dwell cycle of channel 3, then restart.
    run = 1'b0; chan_mask = 8'hFF;
    tick(); tick();
    run = 1'b1;
    wait_model(3, int'(BL) + 1, "run_drop_wait");
    run = 1'b0;
    tick(); tick();
    chan_mask = 8'b0110_0000;
    run = 1'b1;
    repeat (3 * SLOT) tick();

    // Mask cleared mid-dwell of channel 1.
    run = 1'b0; tick();
    run = 1'b1; chan_mask = 8'hFF;
    wait_model(1, int'(BL) + 1, "mask_clear_wait");
    chan_mask = 8'h00;
    repeat (SLOT + 2) tick();

    // Asynchronous reset mid-dwell, then restart.
    chan_mask = 8'b0011_1000;
    wait_model(4, int'(BL) + 2, "rst_wait");
    async_reset_check("async_rst_mid_dwell");
    repeat (3 * SLOT) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 7))
          0:       chan_mask = 8'h00;
          1, 2:    chan_mask = 8'h01 << $urandom_range(0, 7);
          default: chan_mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 39) == 0) run = !run;
      if ($urandom_range(0, 299) == 0) async_reset_check("async_rst_random");
    end

    run = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
